// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Bus sequencer between the MEM-stage load/store datapath and a
// variable-latency data-memory bus with a req/ack handshake. Loads and
// word stores take one bus transfer. Byte and halfword stores take a read
// followed by a write of the word produced by the MEM-stage merge logic.
// The pipeline is stalled while a transfer is in flight. Requests that wait
// too long for an ack are aborted with a one-cycle error pulse.
//
// Parameters:
//   TIMEOUT_CYCLES     request cycles allowed without ack (0 = no timeout)
// Ports:
//   i_Clk_1            clock
//   i_Rst_1            asynchronous active-high reset
//   i_Load_1           MEM-stage load request (level)
//   i_Store_1          MEM-stage store request (level)
//   i_LoadStoreWidth_2 00 byte, 01 half, 1x word
//   i_Address_32       byte address
//   i_StoreData_32     store data for word stores
//   i_MergedData_32    merged word for byte/half stores
//   o_LoadData_32      last successfully read bus word
//   o_Stall_1          freeze pipeline
//   o_Misaligned_1     misaligned access flag
//   o_BusError_1       one-cycle timeout-abort pulse
//   o_BusReq_1         bus request
//   o_BusWe_1          bus write enable (1 write, 0 read)
//   o_BusAddr_32       word-aligned bus address
//   o_BusWData_32      bus write data
//   i_BusAck_1         bus transfer complete
//   i_BusRData_32      bus read data
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_Clk_1,
    input  logic        i_Rst_1,
    input  logic        i_Load_1,
    input  logic        i_Store_1,
    input  logic [1:0]  i_LoadStoreWidth_2,
    input  logic [31:0] i_Address_32,
    input  logic [31:0] i_StoreData_32,
    input  logic [31:0] i_MergedData_32,
    output logic [31:0] o_LoadData_32,
    output logic        o_Stall_1,
    output logic        o_Misaligned_1,
    output logic        o_BusError_1,
    output logic        o_BusReq_1,
    output logic        o_BusWe_1,
    output logic [31:0] o_BusAddr_32,
    output logic [31:0] o_BusWData_32,
    input  logic        i_BusAck_1,
    input  logic [31:0] i_BusRData_32
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam int CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIMIT_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LIMIT = LIMIT_INT[CW-1:0];

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;

    logic access;
    logic is_word;
    logic misaligned;
    logic needs_read;
    logic expired;

    logic stall_c;
    logic misaligned_c;
    logic bus_error_c;
    logic req_c;
    logic we_c;

    assign access     = i_Load_1 | i_Store_1;
    assign is_word    = i_LoadStoreWidth_2[1];
    assign misaligned = ((i_LoadStoreWidth_2 == 2'b01) & i_Address_32[0])
                      | (is_word & (|i_Address_32[1:0]));
    // A load wins over a simultaneous store; sub-word stores need the old word first.
    assign needs_read = i_Load_1 | ~is_word;
    // An ack in the final allowed cycle still counts as a normal completion.
    assign expired    = (TIMEOUT_CYCLES > 0) && (wait_cnt == LIMIT) && !i_BusAck_1;

    // State register
    always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
        if (i_Rst_1) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    state_next = needs_read ? READ : WRITE;
                end
            end
            READ: begin
                if (i_BusAck_1) begin
                    state_next = i_Load_1 ? DONE : WRITE;
                end else if (expired) begin
                    state_next = ERR;
                end
            end
            WRITE: begin
                if (i_BusAck_1) begin
                    state_next = DONE;
                end else if (expired) begin
                    state_next = ERR;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        stall_c      = 1'b0;
        misaligned_c = 1'b0;
        bus_error_c  = 1'b0;
        req_c        = 1'b0;
        we_c         = 1'b0;
        case (state)
            IDLE: begin
                stall_c      = access & ~misaligned;
                misaligned_c = access & misaligned;
            end
            READ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
            end
            WRITE: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                stall_c = 1'b1;
            end
            ERR:     bus_error_c = 1'b1;
            default: ;
        endcase
    end

    // Outputs are forced low while reset is held so the bus sees req drop at once.
    assign o_Stall_1      = stall_c & ~i_Rst_1;
    assign o_Misaligned_1 = misaligned_c & ~i_Rst_1;
    assign o_BusError_1   = bus_error_c & ~i_Rst_1;
    assign o_BusReq_1     = req_c & ~i_Rst_1;
    assign o_BusWe_1      = we_c & ~i_Rst_1;
    assign o_BusAddr_32   = i_Rst_1 ? 32'h0 : {i_Address_32[31:2], 2'b00};
    assign o_BusWData_32  = i_Rst_1 ? 32'h0 : (is_word ? i_StoreData_32 : i_MergedData_32);

    // Read capture and request-wait counter; the counter restarts on every state change.
    always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
        if (i_Rst_1) begin
            o_LoadData_32 <= 32'h0;
            wait_cnt      <= '0;
        end else begin
            if (state == READ && i_BusAck_1) begin
                o_LoadData_32 <= i_BusRData_32;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == READ || state == WRITE) && !i_BusAck_1
                         && (TIMEOUT_CYCLES > 0)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed and randomized transactions against mem_access_ctrl. Each
// transaction is predicted at transaction level (number of stalled cycles,
// request cycles per phase, addresses, write data, abort, captured word)
// and compared with what a simple bus slave observes on the DUT pins.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_in, st_in;
    logic [1:0]  width_in;
    logic [31:0] addr_in, sdata_in, mdata_in;
    logic [31:0] load_data;
    logic        stall, mis_flag, bus_err, req, we;
    logic [31:0] bus_addr, bus_wdata;
    logic        ack;
    logic [31:0] rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_ld;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_Clk_1           (clk),
        .i_Rst_1           (rst),
        .i_Load_1          (ld_in),
        .i_Store_1         (st_in),
        .i_LoadStoreWidth_2(width_in),
        .i_Address_32      (addr_in),
        .i_StoreData_32    (sdata_in),
        .i_MergedData_32   (mdata_in),
        .o_LoadData_32     (load_data),
        .o_Stall_1         (stall),
        .o_Misaligned_1    (mis_flag),
        .o_BusError_1      (bus_err),
        .o_BusReq_1        (req),
        .o_BusWe_1         (we),
        .o_BusAddr_32      (bus_addr),
        .o_BusWData_32     (bus_wdata),
        .i_BusAck_1        (ack),
        .i_BusRData_32     (rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // A phase that never acks, or acks later than allowed, is cut off after T request cycles.
    function automatic bit timesOut(input int lat);
        return (lat == 0) || (lat > T);
    endfunction

    function automatic int reqCycles(input int lat);
        return timesOut(lat) ? T : lat;
    endfunction

    // Runs one MEM-stage access; rlat/wlat give the request cycle that gets the ack (0 = never).
    task automatic applyStimulus(input string name, input logic ld, input logic st,
                                 input logic [1:0] w, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] md,
                                 input logic [31:0] rd, input int rlat, input int wlat);
        bit          acc, mis, need_r, need_w, r_to, w_to, hung, ended;
        int          e_rd, e_wr, e_stall;
        logic [31:0] e_ld, e_wd, e_addr;
        int          rd_n, wr_n, o_stall, o_err, unstable, cyc;
        logic [31:0] o_raddr, o_waddr, o_wdata, o_ld;
        logic        o_mis, o_req_end;

        acc     = ld | st;
        mis     = acc && ((w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00));
        need_r  = acc && !mis && (ld || !w[1]);
        need_w  = acc && !mis && !ld;
        r_to    = need_r && timesOut(rlat);
        e_rd    = need_r ? reqCycles(rlat) : 0;
        e_wr    = (need_w && !r_to) ? reqCycles(wlat) : 0;
        w_to    = need_w && !r_to && timesOut(wlat);
        e_stall = (acc && !mis) ? 1 + e_rd + e_wr : 0;
        e_ld    = (need_r && !r_to) ? rd : prev_ld;
        e_wd    = w[1] ? sd : md;
        e_addr  = {a[31:2], 2'b00};

        rd_n = 0; wr_n = 0; o_stall = 0; o_err = 0; unstable = 0; cyc = 0;
        o_raddr = '0; o_waddr = '0; o_wdata = '0; o_ld = '0; o_req_end = 1'b0;
        hung = 0; ended = 0;

        ld_in = ld; st_in = st; width_in = w; addr_in = a; sdata_in = sd; mdata_in = md;
        ack = 1'b0; rdata = '0;
        #1;
        o_mis = mis_flag;
        while (!ended && !hung) begin
            if (!stall) begin
                ended     = 1;
                o_ld      = load_data;
                o_req_end = req;
                o_err     = o_err + int'(bus_err);
            end else begin
                o_stall++;
                o_err = o_err + int'(bus_err);
                if (req) begin
                    if (!we) begin
                        if (rd_n == 0) o_raddr = bus_addr;
                        else if (bus_addr !== o_raddr) unstable++;
                        rd_n++;
                        ack = (rd_n == rlat);
                    end else begin
                        if (wr_n == 0) begin
                            o_waddr = bus_addr;
                            o_wdata = bus_wdata;
                        end else if (bus_addr !== o_waddr || bus_wdata !== o_wdata) begin
                            unstable++;
                        end
                        wr_n++;
                        ack = (wr_n == wlat);
                    end
                    rdata = ack ? rd : $urandom;
                end else begin
                    ack   = 1'($urandom_range(0, 1));
                    rdata = $urandom;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (cyc > 60) hung = 1;
            end
        end

        // Pipeline advances at this edge; a stray ack here must not be captured.
        ack = 1'($urandom_range(0, 1));
        rdata = $urandom;
        ld_in = 1'b0; st_in = 1'b0;
        @(posedge clk);
        #1;
        ack = 1'b0;

        checkOutput({name, ".bound"}, 32'(hung), 32'd0);
        checkOutput({name, ".stall"}, o_stall, e_stall);
        checkOutput({name, ".rdreq"}, rd_n, e_rd);
        checkOutput({name, ".wrreq"}, wr_n, e_wr);
        checkOutput({name, ".err"}, o_err, 32'(r_to | w_to));
        checkOutput({name, ".mis"}, 32'(o_mis), 32'(mis));
        checkOutput({name, ".ldata"}, o_ld, e_ld);
        checkOutput({name, ".ldhold"}, load_data, e_ld);
        checkOutput({name, ".stable"}, unstable, 32'd0);
        checkOutput({name, ".reqend"}, 32'(o_req_end), 32'd0);
        if (need_r) checkOutput({name, ".raddr"}, o_raddr, e_addr);
        if (e_wr > 0) begin
            checkOutput({name, ".waddr"}, o_waddr, e_addr);
            checkOutput({name, ".wdata"}, o_wdata, e_wd);
        end
        prev_ld = e_ld;
    endtask

    initial begin
        int          r;
        int          rl, wl;
        logic [31:0] ra;

        rst = 1'b1;
        ld_in = 1'b1; st_in = 1'b0; width_in = 2'b10; addr_in = 32'h0;
        sdata_in = '0; mdata_in = '0; ack = 1'b0; rdata = '0;
        prev_ld = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.req", 32'(req), 32'd0);
        checkOutput("reset.ldata", load_data, 32'd0);
        ld_in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed transactions");
        applyStimulus("lw_ack3", 1, 0, 2'b10, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 3, 0);
        applyStimulus("sb_rmw", 0, 1, 2'b00, 32'h203, 32'h0, 32'hAA223344, 32'h11223344, 1, 1);
        applyStimulus("sw_fast", 0, 1, 2'b10, 32'h300, 32'h12345678, 32'h0, 32'h0, 0, 1);
        applyStimulus("lh_mis", 1, 0, 2'b01, 32'h101, 32'h0, 32'h0, 32'h0, 1, 0);
        applyStimulus("sw_mis", 0, 1, 2'b10, 32'h302, 32'h0, 32'h0, 32'h0, 0, 1);
        applyStimulus("ld_st", 1, 1, 2'b10, 32'h100, 32'h55555555, 32'h0, 32'hCAFEF00D, 2, 1);
        applyStimulus("lw_timeout", 1, 0, 2'b10, 32'h108, 32'h0, 32'h0, 32'h77777777, 0, 0);
        applyStimulus("lw_ack16", 1, 0, 2'b10, 32'h10C, 32'h0, 32'h0, 32'h01020304, 16, 0);
        applyStimulus("sh_wr_to", 0, 1, 2'b01, 32'h402, 32'h0, 32'hBEEF0000, 32'h9999AAAA, 2, 0);

        $display("[TB] reset in the middle of a write");
        ld_in = 1'b0; st_in = 1'b1; width_in = 2'b10; addr_in = 32'h500; sdata_in = 32'hFEEDFACE;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstmid.reqbefore", 32'(req), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rstmid.req", 32'(req), 32'd0);
        checkOutput("rstmid.stall", 32'(stall), 32'd0);
        checkOutput("rstmid.err", 32'(bus_err), 32'd0);
        checkOutput("rstmid.ldata", load_data, 32'd0);
        st_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_ld = 32'h0;
        @(posedge clk);
        #1;
        applyStimulus("after_rst", 1, 0, 2'b00, 32'h601, 32'h0, 32'h0, 32'h0BADCAFE, 1, 0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            rl = (r < 8) ? $urandom_range(1, 4) : ((r == 8) ? 16 : 0);
            r  = $urandom_range(0, 9);
            wl = (r < 8) ? $urandom_range(1, 4) : ((r == 8) ? 17 : 16);
            ra = $urandom;
            applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
                          $urandom, $urandom, $urandom, rl, wl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
